// File: rtl/fifo_param_if.sv
// Producer/consumer handshake bundle for fifo_param: requests, data, thresholds and status.
interface fifo_param_if #(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8
);
  localparam int ADDR = $clog2(LENGTH);

  logic                 Fifo_wr;
  logic                 Fifo_rd;
  logic [BITNUMBER-1:0] Fifo_Data_in;
  logic [ADDR:0]        umbral_full;
  logic [ADDR:0]        umbral_empty;
  logic                 err_clr;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 Fifo_valid;
  logic [ADDR:0]        Fifo_count;
  logic                 Fifo_full;
  logic                 Fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 Fifo_wr_error;
  logic                 Fifo_rd_error;
  logic                 Fifo_error;

  modport master (
    output Fifo_wr, Fifo_rd, Fifo_Data_in, umbral_full, umbral_empty, err_clr,
    input  Fifo_Data_out, Fifo_valid, Fifo_count, Fifo_full, Fifo_empty,
           almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_error
  );

  modport slave (
    input  Fifo_wr, Fifo_rd, Fifo_Data_in, umbral_full, umbral_empty, err_clr,
    output Fifo_Data_out, Fifo_valid, Fifo_count, Fifo_full, Fifo_empty,
           almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_error
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with run-time thresholds, occupancy count,
// registered read data with valid strobe, and a sticky software-clearable error.
module fifo_param #(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8
) (
  input logic         clk,
  input logic         reset,
  fifo_param_if.slave bus
);
  localparam int            ADDR  = $clog2(LENGTH);
  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(LENGTH);

  logic [BITNUMBER-1:0] mem [LENGTH];
  logic [ADDR-1:0]      wr_ptr;
  logic [ADDR-1:0]      rd_ptr;
  logic [ADDR:0]        count;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid;
  logic                 wr_error;
  logic                 rd_error;
  logic                 error;

  logic full, empty, wr_ok, rd_ok, wr_rej, rd_rej;

  always_comb begin
    full   = (count == DEPTH);
    empty  = (count == '0);
    rd_ok  = bus.Fifo_rd && !empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    wr_ok  = bus.Fifo_wr && (!full || rd_ok);
    wr_rej = bus.Fifo_wr && !wr_ok;
    rd_rej = bus.Fifo_rd && !rd_ok;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.Fifo_Data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      wr_error <= 1'b0;
      rd_error <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      valid <= rd_ok;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
      wr_error <= wr_rej;
      rd_error <= rd_rej;
      // New errors take priority over a simultaneous clear.
      error    <= wr_rej || rd_rej || (error && !bus.err_clr);
    end
  end

  always_comb begin
    bus.Fifo_Data_out = data_out;
    bus.Fifo_valid    = valid;
    bus.Fifo_count    = count;
    bus.Fifo_full     = full;
    bus.Fifo_empty    = empty;
    bus.almost_full   = (count >= bus.umbral_full);
    bus.almost_empty  = (count <= bus.umbral_empty);
    bus.Fifo_wr_error = wr_error;
    bus.Fifo_rd_error = rd_error;
    bus.Fifo_error    = error;
  end
endmodule
